cordic_scheduler: RTL

- Shares one CORDIC cosine pipeline (float in, float out, fixed LATENCY) between two requesters, e.g. two Nios custom-instruction ports.
- Round-robin arbitration issues at most one operand per clock into the pipeline.
- Tracks each operand's owner through a tag delay line matching the pipeline depth.
- Steers each result into a per-requester output FIFO with valid/ready; credit counters guarantee the FIFOs never overflow.

---
 rtl/cordic_scheduler.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/cordic_scheduler.sv
// cordic_scheduler: lets two requesters share one fixed-latency CORDIC cosine
// pipeline. A round-robin arbiter issues at most one operand per clock, and a
// tag delay line records who owns each operand. Each result lands in that
// owner's show-ahead FIFO. Per-requester credit counters stop a requester
// before its FIFO could overflow.
module cordic_scheduler #(
  parameter int W          = 32,
  parameter int LATENCY    = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_data,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_data,
  output logic         res0_valid,
  input  logic         res0_ready,
  output logic [W-1:0] res0_data,
  output logic         res1_valid,
  input  logic         res1_ready,
  output logic [W-1:0] res1_data,
  output logic [W-1:0] cordic_dataa,
  input  logic [W-1:0] cordic_result,
  output logic         busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  // Per-requester views of the ports (index 0 = requester 0).
  logic [1:0] req_valid;
  logic [1:0] res_ready;
  logic [1:0] elig;
  logic [1:0] grant;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] res_valid;
  logic       accept;
  logic       capture;
  logic       cap_id;

  logic              last_grant_q, last_grant_d;
  logic [LATENCY-1:0] tag_v_q, tag_v_d;
  logic [LATENCY-1:0] tag_id_q, tag_id_d;
  logic [CW-1:0]     outst_q [2];
  logic [CW-1:0]     outst_d [2];
  logic [CW-1:0]     count_q [2];
  logic [CW-1:0]     count_d [2];
  logic [PW-1:0]     wr_ptr_q [2];
  logic [PW-1:0]     wr_ptr_d [2];
  logic [PW-1:0]     rd_ptr_q [2];
  logic [PW-1:0]     rd_ptr_d [2];
  logic [W-1:0]      mem_q [2][FIFO_DEPTH];
  logic [W-1:0]      head  [2];

  assign req_valid = {req1_valid, req0_valid};
  assign res_ready = {res1_ready, res0_ready};

  // Eligibility: valid and holding a free credit; nothing is granted in reset.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    elig = '0;
    for (int n = 0; n < 2; n++) begin
      elig[n] = req_valid[n] && (outst_q[n] < DEPTH_C) && !rst;
    end
  end

  // Round-robin grant: on a tie, the requester that did not win last time wins.
  always_comb begin
    grant = elig;
    if (elig == 2'b11) begin
      grant = last_grant_q ? 2'b01 : 2'b10;
    end
    accept       = |grant;
    last_grant_d = accept ? grant[1] : last_grant_q;
  end

  // Operand mux into the CORDIC; zero when nothing is issued.
  always_comb begin
    cordic_dataa = '0;
    if (grant[0]) begin
      cordic_dataa = req0_data;
    end else if (grant[1]) begin
      cordic_dataa = req1_data;
    end
  end

  // Tag delay line: each stage marks which requester owns the operand at that depth.
  always_comb begin
    tag_v_d  = {tag_v_q[LATENCY-2:0], accept};
    tag_id_d = {tag_id_q[LATENCY-2:0], grant[1]};
  end

  assign capture = tag_v_q[LATENCY-1];
  assign cap_id  = tag_id_q[LATENCY-1];
  assign push    = {capture & cap_id, capture & ~cap_id};

  // FIFO and credit bookkeeping for both requesters.
  always_comb begin
    res_valid = '0;
    pop       = '0;
    for (int n = 0; n < 2; n++) begin
      res_valid[n] = (count_q[n] != '0);
      pop[n]       = res_valid[n] && res_ready[n];
      head[n]      = res_valid[n] ? mem_q[n][rd_ptr_q[n]] : '0;

      count_d[n] = count_q[n];
      case ({push[n], pop[n]})
        2'b10:   count_d[n] = count_q[n] + CNT_ONE;
        2'b01:   count_d[n] = count_q[n] - CNT_ONE;
        default: count_d[n] = count_q[n];
      endcase

      outst_d[n] = outst_q[n];
      case ({grant[n], pop[n]})
        2'b10:   outst_d[n] = outst_q[n] + CNT_ONE;
        2'b01:   outst_d[n] = outst_q[n] - CNT_ONE;
        default: outst_d[n] = outst_q[n];
      endcase

      wr_ptr_d[n] = push[n] ? wr_ptr_q[n] + PTR_ONE : wr_ptr_q[n];
      rd_ptr_d[n] = pop[n]  ? rd_ptr_q[n] + PTR_ONE : rd_ptr_q[n];
    end
  end

  // Control state: arbitration history, tags, credits, FIFO pointers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      last_grant_q <= 1'b1;
      tag_v_q      <= '0;
      tag_id_q     <= '0;
      for (int n = 0; n < 2; n++) begin
        outst_q[n]  <= '0;
        count_q[n]  <= '0;
        wr_ptr_q[n] <= '0;
        rd_ptr_q[n] <= '0;
      end
    end else begin
      last_grant_q <= last_grant_d;
      tag_v_q      <= tag_v_d;
      tag_id_q     <= tag_id_d;
      for (int n = 0; n < 2; n++) begin
        outst_q[n]  <= outst_d[n];
        count_q[n]  <= count_d[n];
        wr_ptr_q[n] <= wr_ptr_d[n];
        rd_ptr_q[n] <= rd_ptr_d[n];
      end
    end
  end

  // Result storage: capture the CORDIC output into its owner's FIFO.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset. Empty slots are never observable,
    // because the head output is forced to zero while the FIFO is empty.
    for (int n = 0; n < 2; n++) begin
      if (push[n]) begin
        mem_q[n][wr_ptr_q[n]] <= cordic_result;
      end
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign res0_valid = res_valid[0];
  assign res1_valid = res_valid[1];
  assign res0_data  = head[0];
  assign res1_data  = head[1];
  assign busy       = (|tag_v_q) | (|res_valid);

endmodule
